// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, default latencies,
// FSM state type and the op-class decoder.
// Optional feature macro: MDU_MADD_EN (madd/maddu/msub/msubu accumulate ops).
package mult_div_unit_pkg;

  // HI/LO-class operation codes; 0 and unlisted codes are no-ops.
  localparam logic [3:0] OpNop   = 4'd0;
  localparam logic [3:0] OpMult  = 4'd1;
  localparam logic [3:0] OpMultu = 4'd2;
  localparam logic [3:0] OpDiv   = 4'd3;
  localparam logic [3:0] OpDivu  = 4'd4;
  localparam logic [3:0] OpMthi  = 4'd5;
  localparam logic [3:0] OpMtlo  = 4'd6;
  localparam logic [3:0] OpMadd  = 4'd7;
  localparam logic [3:0] OpMaddu = 4'd8;
  localparam logic [3:0] OpMsub  = 4'd9;
  localparam logic [3:0] OpMsubu = 4'd10;

  localparam int unsigned MduMultCyclesDef = 5;
  localparam int unsigned MduDivCyclesDef  = 10;

  typedef enum logic [0:0] {StIdle, StRun} mdu_state_e;

  typedef enum logic [2:0] {ClsNone, ClsMul, ClsDiv, ClsMthi, ClsMtlo} op_class_e;

  // Groups op codes by how the unit schedules them.
  function automatic op_class_e op_class(logic [3:0] op);
    op_class_e cls;
    case (op)
      OpMult, OpMultu: cls = ClsMul;
`ifdef MDU_MADD_EN
      OpMadd, OpMaddu, OpMsub, OpMsubu: cls = ClsMul;
`endif
      OpDiv, OpDivu: cls = ClsDiv;
      OpMthi:        cls = ClsMthi;
      OpMtlo:        cls = ClsMtlo;
      default:       cls = ClsNone;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/mdu_alu.sv
// Combinational arithmetic for the multiply/divide unit. Produces the
// {phi, plo} result for the given op and flags a zero divisor.
// Optional feature macro: MDU_MADD_EN (adds accumulate/subtract ops on HI/LO).
module mdu_alu
  import mult_div_unit_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [31:0] phi,
  output logic [31:0] plo,
  output logic        div_zero
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] b_safe;
  logic [31:0] a_mag, b_mag;
  logic [31:0] sq_mag, sr_mag;
  logic [31:0] sq, sr;
  logic [31:0] uq, ur;

`ifndef MDU_MADD_EN
  logic unused_acc;
  assign unused_acc = ^{hi, lo};
`endif

  // Products, quotients and remainders for every op class, then select by op.
  always_comb begin
    prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    prod_u = {32'b0, a} * {32'b0, b};

    // Keep the dividers free of a zero divisor; the result is discarded anyway.
    b_safe = (b == 32'd0) ? 32'd1 : b;
    uq     = a / b_safe;
    ur     = a % b_safe;

    // Sign-magnitude division. 0x80000000 / -1 falls out as quotient
    // 0x80000000, remainder 0 without a special case.
    a_mag  = a[31] ? (32'd0 - a) : a;
    b_mag  = b_safe[31] ? (32'd0 - b_safe) : b_safe;
    sq_mag = a_mag / b_mag;
    sr_mag = a_mag % b_mag;
    sq     = (a[31] ^ b_safe[31]) ? (32'd0 - sq_mag) : sq_mag;
    sr     = a[31] ? (32'd0 - sr_mag) : sr_mag;

    div_zero   = 1'b0;
    {phi, plo} = 64'd0;
    case (op)
      OpMult:  {phi, plo} = prod_s;
      OpMultu: {phi, plo} = prod_u;
      OpDiv: begin
        {phi, plo} = {sr, sq};
        div_zero   = (b == 32'd0);
      end
      OpDivu: begin
        {phi, plo} = {ur, uq};
        div_zero   = (b == 32'd0);
      end
`ifdef MDU_MADD_EN
      OpMadd:  {phi, plo} = {hi, lo} + prod_s;
      OpMaddu: {phi, plo} = {hi, lo} + prod_u;
      OpMsub:  {phi, plo} = {hi, lo} - prod_s;
      OpMsubu: {phi, plo} = {hi, lo} - prod_u;
`endif
      default: {phi, plo} = 64'd0;
    endcase
  end

endmodule

// File: rtl/mult_div_unit.sv
// Multiply/divide unit: owns architectural HI/LO, runs a fixed-latency busy
// window per long op and commits the pending result when the window closes.
// Optional feature macro: MDU_MADD_EN (madd/maddu/msub/msubu).
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MduMultCyclesDef,
  parameter int unsigned DIV_CYCLES  = MduDivCyclesDef
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  mdu_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     hi_q, hi_d, lo_q, lo_d;
  logic [31:0]     phi_q, phi_d, plo_q, plo_d;
  logic            wr_q, wr_d;  // pending result is to be committed (clear on div-by-zero)

  logic [31:0] alu_hi, alu_lo;
  logic        alu_div_zero;

  mdu_alu u_alu (
    .op       (op),
    .a        (A),
    .b        (B),
    .hi       (hi_q),
    .lo       (lo_q),
    .phi      (alu_hi),
    .plo      (alu_lo),
    .div_zero (alu_div_zero)
  );

  // Next-state: accept starts in idle, count down in run, commit on the last edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    phi_d   = phi_q;
    plo_d   = plo_q;
    wr_d    = wr_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          case (op_class(op))
            ClsMul: begin
              state_d = StRun;
              cnt_d   = CntW'(MULT_CYCLES);
              phi_d   = alu_hi;
              plo_d   = alu_lo;
              wr_d    = 1'b1;
            end
            ClsDiv: begin
              state_d = StRun;
              cnt_d   = CntW'(DIV_CYCLES);
              phi_d   = alu_hi;
              plo_d   = alu_lo;
              wr_d    = ~alu_div_zero;
            end
            ClsMthi: hi_d = A;
            ClsMtlo: lo_d = A;
            default: ;
          endcase
        end
      end
      StRun: begin
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d = StIdle;
          wr_d    = 1'b0;
          if (wr_q) begin
            hi_d = phi_q;
            lo_d = plo_q;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset discards any in-flight result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      phi_q   <= '0;
      plo_q   <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      phi_q   <= phi_d;
      plo_q   <= plo_d;
      wr_q    <= wr_d;
    end
  end

  assign busy = (state_q == StRun);
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed scenarios plus randomized
// ops checked against a plain-arithmetic reference model.
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  op;
  logic [31:0] a, b;
  logic        dut_busy;
  logic [31:0] dut_hi, dut_lo;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] hi_m, lo_m;

  mult_div_unit #(
    .MULT_CYCLES (MC),
    .DIV_CYCLES  (DC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .A     (a),
    .B     (b),
    .busy  (dut_busy),
    .HI    (dut_hi),
    .LO    (dut_lo)
  );

  always #5 clk = ~clk;

  // Reference model: architectural effect of an op and its busy length.
  task automatic model_exec(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                            output int lat);
    longint      sx, sy, q, r;
    logic [63:0] acc;
    sx  = longint'($signed(x));
    sy  = longint'($signed(y));
    lat = 0;
    acc = {hi_m, lo_m};
    case (o)
      OpMult:  begin acc = 64'(sx * sy); lat = MC; end
      OpMultu: begin acc = {32'b0, x} * {32'b0, y}; lat = MC; end
      OpDiv: begin
        lat = DC;
        if (y != 0) begin
          q = sx / sy;
          r = sx % sy;
          acc = {r[31:0], q[31:0]};
        end
      end
      OpDivu: begin
        lat = DC;
        if (y != 0) acc = {x % y, x / y};
      end
      OpMthi: acc[63:32] = x;
      OpMtlo: acc[31:0] = x;
`ifdef MDU_MADD_EN
      OpMadd:  begin acc = acc + 64'(sx * sy); lat = MC; end
      OpMaddu: begin acc = acc + {32'b0, x} * {32'b0, y}; lat = MC; end
      OpMsub:  begin acc = acc - 64'(sx * sy); lat = MC; end
      OpMsubu: begin acc = acc - {32'b0, x} * {32'b0, y}; lat = MC; end
`endif
      default: ;
    endcase
    {hi_m, lo_m} = acc;
  endtask

  // Presents one start for a single edge; returns #1 after that edge.
  task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(posedge clk);
    #1;
    start = 1'b0;
    op    = OpNop;
    a     = $urandom;
    b     = $urandom;
  endtask

  // Counts busy cycles (bounded) until the unit is idle.
  task automatic wait_idle(output int n);
    n = 0;
    while (dut_busy === 1'b1 && n < 40) begin
      n++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    start = 1'b0;
    op    = OpNop;
    a     = '0;
    b     = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (dut_busy !== 1'b0) begin
      n_errors++; $display("FAIL reset_busy: got %b expected 0", dut_busy);
    end
    n_checks++;
    if (dut_hi !== 32'h0) begin
      n_errors++; $display("FAIL reset_hi: got %h expected 0", dut_hi);
    end
    n_checks++;
    if (dut_lo !== 32'h0) begin
      n_errors++; $display("FAIL reset_lo: got %h expected 0", dut_lo);
    end
    reset = 1'b0;
    hi_m  = '0;
    lo_m  = '0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_mult;
    int n, lat;
    model_exec(OpMult, 32'hFFFF_FFFF, 32'd2, lat);
    issue(OpMult, 32'hFFFF_FFFF, 32'd2);
    wait_idle(n);
    n_checks++;
    if (n != MC) begin n_errors++; $display("FAIL mult_busy: got %0d expected %0d", n, MC); end
    n_checks++;
    if (dut_hi !== 32'hFFFF_FFFF || dut_lo !== 32'hFFFF_FFFE) begin
      n_errors++; $display("FAIL mult_result: got %h_%h expected ffffffff_fffffffe", dut_hi, dut_lo);
    end
    model_exec(OpMultu, 32'hFFFF_FFFF, 32'd2, lat);
    issue(OpMultu, 32'hFFFF_FFFF, 32'd2);
    wait_idle(n);
    n_checks++;
    if (n != MC) begin n_errors++; $display("FAIL multu_busy: got %0d expected %0d", n, MC); end
    n_checks++;
    if (dut_hi !== 32'h0000_0001 || dut_lo !== 32'hFFFF_FFFE) begin
      n_errors++; $display("FAIL multu_result: got %h_%h expected 00000001_fffffffe", dut_hi, dut_lo);
    end
  endtask

  task automatic test_div;
    int n, lat;
    model_exec(OpDiv, 32'hFFFF_FFF9, 32'd2, lat);
    issue(OpDiv, 32'hFFFF_FFF9, 32'd2);
    wait_idle(n);
    n_checks++;
    if (n != DC) begin n_errors++; $display("FAIL div_busy: got %0d expected %0d", n, DC); end
    n_checks++;
    if (dut_hi !== 32'hFFFF_FFFF || dut_lo !== 32'hFFFF_FFFD) begin
      n_errors++; $display("FAIL div_result: got %h_%h expected ffffffff_fffffffd", dut_hi, dut_lo);
    end
    model_exec(OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, lat);
    issue(OpDiv, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(n);
    n_checks++;
    if (dut_hi !== 32'h0 || dut_lo !== 32'h8000_0000) begin
      n_errors++; $display("FAIL div_overflow: got %h_%h expected 00000000_80000000", dut_hi, dut_lo);
    end
  endtask

  task automatic test_div_zero;
    int n, lat;
    model_exec(OpMthi, 32'h11, 32'd0, lat);
    issue(OpMthi, 32'h11, 32'd0);
    model_exec(OpMtlo, 32'h22, 32'd0, lat);
    issue(OpMtlo, 32'h22, 32'd0);
    model_exec(OpDivu, 32'd5, 32'd0, lat);
    issue(OpDivu, 32'd5, 32'd0);
    wait_idle(n);
    n_checks++;
    if (n != DC) begin n_errors++; $display("FAIL divzero_busy: got %0d expected %0d", n, DC); end
    n_checks++;
    if (dut_hi !== 32'h11 || dut_lo !== 32'h22) begin
      n_errors++; $display("FAIL divzero_keep: got %h_%h expected 00000011_00000022", dut_hi, dut_lo);
    end
  endtask

  task automatic test_move;
    int lat;
    bit saw_busy;
    model_exec(OpMthi, 32'h1234, 32'd0, lat);
    issue(OpMthi, 32'h1234, 32'd0);
    saw_busy = (dut_busy !== 1'b0);
    n_checks++;
    if (dut_hi !== 32'h1234 || dut_lo !== lo_m) begin
      n_errors++; $display("FAIL mthi: got %h_%h expected %h_%h", dut_hi, dut_lo, 32'h1234, lo_m);
    end
    repeat (3) begin
      @(posedge clk);
      #1;
      if (dut_busy !== 1'b0) saw_busy = 1'b1;
    end
    n_checks++;
    if (saw_busy) begin n_errors++; $display("FAIL mthi_busy: got 1 expected 0"); end
  endtask

  task automatic test_ignore_in_run;
    int n, lat;
    model_exec(OpMult, 32'd7, 32'd9, lat);
    issue(OpMult, 32'd7, 32'd9);
    @(posedge clk);
    #1;
    issue(OpMult, 32'hFFFF_0000, 32'h1234_5678);
    wait_idle(n);
    n_checks++;
    if (n != MC - 2) begin n_errors++; $display("FAIL ignore_busy: got %0d expected %0d", n, MC - 2); end
    n_checks++;
    if (dut_hi !== 32'h0 || dut_lo !== 32'd63) begin
      n_errors++; $display("FAIL ignore_result: got %h_%h expected 00000000_0000003f", dut_hi, dut_lo);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (dut_busy !== 1'b0) begin n_errors++; $display("FAIL ignore_relaunch: got %b expected 0", dut_busy); end
  endtask

  task automatic test_reset_mid_run;
    int lat;
    bit late;
    model_exec(OpMthi, 32'h55, 32'd0, lat);
    issue(OpMthi, 32'h55, 32'd0);
    issue(OpMult, 32'd3, 32'd4);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (dut_busy !== 1'b0 || dut_hi !== 32'h0 || dut_lo !== 32'h0) begin
      n_errors++;
      $display("FAIL reset_mid_run: got busy=%b %h_%h expected busy=0 00000000_00000000",
               dut_busy, dut_hi, dut_lo);
    end
    hi_m = '0;
    lo_m = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    late  = 1'b0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (dut_busy !== 1'b0 || dut_hi !== 32'h0 || dut_lo !== 32'h0) late = 1'b1;
    end
    n_checks++;
    if (late) begin
      n_errors++; $display("FAIL reset_late_write: got busy=%b %h_%h expected 0 0_0", dut_busy, dut_hi, dut_lo);
    end
  endtask

  task automatic test_madd;
    int n, lat;
    model_exec(OpMthi, 32'h0, 32'd0, lat);
    issue(OpMthi, 32'h0, 32'd0);
    model_exec(OpMtlo, 32'hFFFF_FFFF, 32'd0, lat);
    issue(OpMtlo, 32'hFFFF_FFFF, 32'd0);
    model_exec(OpMaddu, 32'd1, 32'd1, lat);
    issue(OpMaddu, 32'd1, 32'd1);
`ifdef MDU_MADD_EN
    wait_idle(n);
    n_checks++;
    if (n != MC) begin n_errors++; $display("FAIL maddu_busy: got %0d expected %0d", n, MC); end
    n_checks++;
    if (dut_hi !== 32'h1 || dut_lo !== 32'h0) begin
      n_errors++; $display("FAIL maddu_result: got %h_%h expected 00000001_00000000", dut_hi, dut_lo);
    end
`else
    n_checks++;
    if (dut_busy !== 1'b0) begin n_errors++; $display("FAIL maddu_nop_busy: got %b expected 0", dut_busy); end
    wait_idle(n);
    n_checks++;
    if (dut_hi !== 32'h0 || dut_lo !== 32'hFFFF_FFFF) begin
      n_errors++; $display("FAIL maddu_nop_keep: got %h_%h expected 00000000_ffffffff", dut_hi, dut_lo);
    end
`endif
  endtask

  task automatic test_random;
    int n, lat;
    logic [3:0]  o;
    logic [31:0] x, y;
    for (int i = 0; i < 40; i++) begin
      o = 4'($urandom_range(0, 15));
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 7))
        0: y = 32'd0;
        1: y = 32'hFFFF_FFFF;
        2: x = 32'h8000_0000;
        3: y = 32'($urandom_range(1, 9));
        default: ;
      endcase
      model_exec(o, x, y, lat);
      issue(o, x, y);
      wait_idle(n);
      n_checks++;
      if (n != lat) begin
        n_errors++; $display("FAIL rand_busy[%0d] op=%0d: got %0d expected %0d", i, o, n, lat);
      end
      n_checks++;
      if (dut_hi !== hi_m || dut_lo !== lo_m) begin
        n_errors++;
        $display("FAIL rand_result[%0d] op=%0d a=%h b=%h: got %h_%h expected %h_%h",
                 i, o, x, y, dut_hi, dut_lo, hi_m, lo_m);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_move();
    test_ignore_in_run();
    test_reset_mid_run();
    test_madd();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
